// File: rtl/axi_pkt_rr_arb_4.sv
// Packet-aware four-input round-robin arbiter feeding an AXI-stream FIFO write port.
// A grant is held until its tlast beat; almost_full only blocks new grants.
module axi_pkt_rr_arb_4 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      async_reset,
  input  logic [3:0]                s_axis_tvalid,
  input  logic [4*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [3:0]                s_axis_tlast,
  output logic [3:0]                s_axis_tready,
  input  logic                      fifo_almost_full,
  output logic                      m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic                      grant_active,
  output logic [1:0]                grant_idx
);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e                state_q, state_d;
  logic [1:0]            grant_idx_q, grant_idx_d;
  logic [1:0]            last_grant_q, last_grant_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;

  logic       out_ready;
  logic       accept;
  logic [1:0] pick;
  logic       pick_found;
  logic [1:0] cand;

  assign out_ready = ~out_valid_q | m_axis_tready;
  assign accept    = (state_q == ACTIVE) & s_axis_tvalid[grant_idx_q] & out_ready;

  // Rotating priority: search starts just after the most recently granted requester.
  always_comb begin
    pick       = last_grant_q;
    pick_found = 1'b0;
    cand       = '0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_grant_q + 2'(i);
      if (!pick_found && s_axis_tvalid[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
    end
  end

  // NOTE: every _d gets its current value first so no path through this block infers a latch.
  always_comb begin
    state_d      = state_q;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;

    unique case (state_q)
      IDLE: begin
        if (!fifo_almost_full && pick_found) begin
          grant_idx_d = pick;
          state_d     = ACTIVE;
        end
      end
      ACTIVE: begin
        if (accept && s_axis_tlast[grant_idx_q]) begin
          last_grant_d = grant_idx_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = s_axis_tdata[32'(grant_idx_q) * DATA_WIDTH +: DATA_WIDTH];
      out_last_d  = s_axis_tlast[grant_idx_q];
    end else if (m_axis_tready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state flops use non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state_q      <= IDLE;
      grant_idx_q  <= 2'd0;
      last_grant_q <= 2'd3;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
    end
  end

  always_comb begin
    s_axis_tready = '0;
    if (state_q == ACTIVE) s_axis_tready[grant_idx_q] = out_ready;
  end

  assign grant_active  = (state_q == ACTIVE);
  assign grant_idx     = grant_idx_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tlast  = out_last_q;

endmodule

// File: tb/tb_axi_pkt_rr_arb_4.sv
// Directed bench for axi_pkt_rr_arb_4: per-port packet drivers, output beat log,
// hand-computed expected beat/grant sequences per scenario.
module tb_axi_pkt_rr_arb_4;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              async_reset = 1'b0;
  logic [3:0]        s_axis_tvalid = '0;
  logic [4*DW-1:0]   s_axis_tdata = '0;
  logic [3:0]        s_axis_tlast = '0;
  logic [3:0]        s_axis_tready;
  logic              fifo_almost_full = 1'b0;
  logic              m_axis_tvalid;
  logic [DW-1:0]     m_axis_tdata;
  logic              m_axis_tlast;
  logic              m_axis_tready = 1'b1;
  logic              grant_active;
  logic [1:0]        grant_idx;

  axi_pkt_rr_arb_4 #(.DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .async_reset      (async_reset),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tlast     (s_axis_tlast),
    .s_axis_tready    (s_axis_tready),
    .fifo_almost_full (fifo_almost_full),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tready    (m_axis_tready),
    .grant_active     (grant_active),
    .grant_idx        (grant_idx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit en[4];
  bit hold[4];
  int len[4];
  int quota[4];
  int bcnt[4];
  int pkt[4];

  logic [32:0] beat_q[$];
  int          beat_cyc[$];
  int          gnt_q[$];
  int          gnt_cyc[$];
  bit          prev_ga;

  // Beat payload encodes port, packet number and beat index.
  function automatic logic [31:0] dw(int p, int k, int b);
    return (32'(p) << 28) | (32'(k) << 16) | 32'(b);
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      s_axis_tvalid[i]           = en[i] && !hold[i];
      s_axis_tdata[i*DW +: DW]   = dw(i, pkt[i], bcnt[i]);
      s_axis_tlast[i]            = (bcnt[i] == len[i] - 1);
    end
  endtask

  task automatic new_test();
    beat_q.delete();
    beat_cyc.delete();
    gnt_q.delete();
    gnt_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      en[i] = 0; hold[i] = 0; bcnt[i] = 0; pkt[i] = 0; len[i] = 1; quota[i] = 0;
    end
    fifo_almost_full = 1'b0;
    m_axis_tready    = 1'b1;
    drive();
  endtask

  // One clock: sample handshakes before the edge, log results after it, advance drivers.
  task automatic step();
    logic [3:0]  acc;
    bit          hs;
    logic [32:0] hv;
    #1;
    acc = s_axis_tvalid & s_axis_tready;
    hs  = m_axis_tvalid & m_axis_tready;
    hv  = {m_axis_tlast, m_axis_tdata};
    @(posedge clk);
    #1;
    cyc++;
    if (hs) begin
      beat_q.push_back(hv);
      beat_cyc.push_back(cyc);
    end
    if (grant_active && !prev_ga) begin
      gnt_q.push_back(int'(grant_idx));
      gnt_cyc.push_back(cyc);
    end
    prev_ga = grant_active;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        bcnt[i]++;
        if (bcnt[i] == len[i]) begin
          bcnt[i] = 0;
          pkt[i]++;
        end
      end
      if (pkt[i] >= quota[i]) en[i] = 0;
    end
    drive();
  endtask

  task automatic run_beats(input int n, input int budget, output bit ok);
    int k = 0;
    while (beat_q.size() < n && k < budget) begin
      step();
      k++;
    end
    ok = (beat_q.size() >= n);
  endtask

  task automatic apply_reset();
    new_test();
    async_reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    async_reset = 1'b0;
    @(posedge clk);
    #1;
    prev_ga = grant_active;
  endtask

  task automatic test_reset();
    new_test();
    #2 async_reset = 1'b1;
    #1;
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b want=0", m_axis_tvalid); end
    total++; if (m_axis_tdata !== '0) begin bad++; $display("FAIL reset_tdata got=%h want=0", m_axis_tdata); end
    total++; if (m_axis_tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast got=%b want=0", m_axis_tlast); end
    total++; if (s_axis_tready !== 4'b0) begin bad++; $display("FAIL reset_tready got=%b want=0000", s_axis_tready); end
    total++; if (grant_active !== 1'b0) begin bad++; $display("FAIL reset_grant_active got=%b want=0", grant_active); end
    total++; if (grant_idx !== 2'd0) begin bad++; $display("FAIL reset_grant_idx got=%0d want=0", grant_idx); end
    apply_reset();
  endtask

  task automatic test_single();
    bit ok;
    new_test();
    len[2] = 3; quota[2] = 1; en[2] = 1; drive();
    run_beats(3, 20, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL single_timeout got=%0d beats want=3", beat_q.size());
    end else begin
      total++;
      if (gnt_q.size() != 1 || gnt_q[0] != 2) begin
        bad++; $display("FAIL single_grant got=%p want='{2}", gnt_q);
      end else begin
        total++;
        if (beat_cyc[0] - gnt_cyc[0] != 2) begin
          bad++; $display("FAIL single_latency got=%0d want=2", beat_cyc[0] - gnt_cyc[0]);
        end
      end
      for (int k = 0; k < 3; k++) begin
        total++;
        if (beat_q[k] !== {(k == 2), dw(2, 0, k)}) begin
          bad++; $display("FAIL single_beat%0d got=%h want=%h", k, beat_q[k], {(k == 2), dw(2, 0, k)});
        end
      end
      total++;
      if (beat_cyc[2] - beat_cyc[0] != 2) begin
        bad++; $display("FAIL single_consecutive got=%0d want=2", beat_cyc[2] - beat_cyc[0]);
      end
      total++;
      if (grant_active !== 1'b0 || s_axis_tready !== 4'b0 || m_axis_tvalid !== 1'b0 || grant_idx !== 2'd2) begin
        bad++; $display("FAIL single_end got=ga%b rdy%b mv%b gi%0d want=ga0 rdy0000 mv0 gi2",
                        grant_active, s_axis_tready, m_axis_tvalid, grant_idx);
      end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int order[5] = '{0, 1, 2, 3, 0};
    int pnum[5]  = '{0, 0, 0, 0, 1};
    logic [32:0] exp;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      len[i] = 2; en[i] = 1; quota[i] = (i == 0) ? 2 : 1;
    end
    drive();
    run_beats(10, 60, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL rr_timeout got=%0d beats want=10", beat_q.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        exp = {(k % 2 == 1), dw(order[k/2], pnum[k/2], k % 2)};
        total++;
        if (beat_q[k] !== exp) begin
          bad++; $display("FAIL rr_beat%0d got=%h want=%h", k, beat_q[k], exp);
        end
      end
      total++;
      if (gnt_q.size() != 5) begin
        bad++; $display("FAIL rr_grant_count got=%0d want=5", gnt_q.size());
      end else begin
        for (int g = 0; g < 5; g++) begin
          total++;
          if (gnt_q[g] != order[g]) begin
            bad++; $display("FAIL rr_grant%0d got=%0d want=%0d", g, gnt_q[g], order[g]);
          end
          if (g > 0) begin
            total++;
            if (gnt_cyc[g] - gnt_cyc[g-1] != 3) begin
              bad++; $display("FAIL rr_spacing%0d got=%0d want=3", g, gnt_cyc[g] - gnt_cyc[g-1]);
            end
          end
        end
      end
    end
  endtask

  task automatic test_almost_full();
    bit ok;
    new_test();
    fifo_almost_full = 1'b1;
    len[1] = 3; quota[1] = 1; en[1] = 1; drive();
    for (int k = 0; k < 10; k++) begin
      step();
      total++;
      if (s_axis_tready !== 4'b0 || grant_active !== 1'b0) begin
        bad++; $display("FAIL af_blocked%0d got=rdy%b ga%b want=rdy0000 ga0", k, s_axis_tready, grant_active);
      end
    end
    fifo_almost_full = 1'b0;
    step();
    total++;
    if (grant_active !== 1'b1 || grant_idx !== 2'd1) begin
      bad++; $display("FAIL af_release got=ga%b gi%0d want=ga1 gi1", grant_active, grant_idx);
    end
    fifo_almost_full = 1'b1;
    run_beats(3, 20, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL af_timeout got=%0d beats want=3", beat_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        total++;
        if (beat_q[k] !== {(k == 2), dw(1, 0, k)}) begin
          bad++; $display("FAIL af_beat%0d got=%h want=%h", k, beat_q[k], {(k == 2), dw(1, 0, k)});
        end
      end
      total++;
      if (beat_cyc[2] - beat_cyc[0] != 2) begin
        bad++; $display("FAIL af_uninterrupted got=%0d want=2", beat_cyc[2] - beat_cyc[0]);
      end
    end
    fifo_almost_full = 1'b0;
  endtask

  task automatic test_backpressure();
    bit pat[12] = '{1, 1, 0, 0, 1, 0, 0, 1, 1, 0, 1, 1};
    logic [3:0]    exp_rdy;
    bit            pv, pr;
    logic [DW-1:0] pd;
    int            k = 0;
    new_test();
    len[0] = 4; quota[0] = 1; en[0] = 1; drive();
    while (beat_q.size() < 4 && k < 30) begin
      m_axis_tready = (k < 12) ? pat[k] : 1'b1;
      #1;
      exp_rdy = 4'b0;
      if (grant_active) exp_rdy[0] = ~m_axis_tvalid | m_axis_tready;
      total++;
      if (s_axis_tready !== exp_rdy) begin
        bad++; $display("FAIL bp_tready%0d got=%b want=%b", k, s_axis_tready, exp_rdy);
      end
      pv = m_axis_tvalid; pr = m_axis_tready; pd = m_axis_tdata;
      step();
      if (pv && !pr) begin
        total++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pd) begin
          bad++; $display("FAIL bp_hold%0d got=v%b d%h want=v1 d%h", k, m_axis_tvalid, m_axis_tdata, pd);
        end
      end
      k++;
    end
    m_axis_tready = 1'b1;
    repeat (3) step();
    total++;
    if (beat_q.size() != 4) begin
      bad++; $display("FAIL bp_count got=%0d want=4", beat_q.size());
    end else begin
      for (int b = 0; b < 4; b++) begin
        total++;
        if (beat_q[b] !== {(b == 3), dw(0, 0, b)}) begin
          bad++; $display("FAIL bp_beat%0d got=%h want=%h", b, beat_q[b], {(b == 3), dw(0, 0, b)});
        end
      end
    end
  endtask

  task automatic test_gap();
    bit ok;
    int k = 0;
    logic [32:0] exp;
    new_test();
    len[3] = 4; quota[3] = 1; en[3] = 1;
    len[0] = 2; quota[0] = 1; en[0] = 1;
    drive();
    while (bcnt[3] < 1 && k < 10) begin
      step();
      k++;
    end
    total++;
    if (bcnt[3] < 1 || grant_idx !== 2'd3) begin
      bad++; $display("FAIL gap_first_grant got=gi%0d beats%0d want=gi3 beats1", grant_idx, bcnt[3]);
    end
    hold[3] = 1; drive();
    for (int g = 0; g < 5; g++) begin
      step();
      total++;
      if (grant_active !== 1'b1 || grant_idx !== 2'd3 || s_axis_tready[0] !== 1'b0) begin
        bad++; $display("FAIL gap_hold%0d got=ga%b gi%0d rdy%b want=ga1 gi3 rdy[0]=0",
                        g, grant_active, grant_idx, s_axis_tready);
      end
    end
    hold[3] = 0; drive();
    run_beats(6, 40, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL gap_timeout got=%0d beats want=6", beat_q.size());
    end else begin
      for (int b = 0; b < 6; b++) begin
        exp = (b < 4) ? {(b == 3), dw(3, 0, b)} : {(b == 5), dw(0, 0, b - 4)};
        total++;
        if (beat_q[b] !== exp) begin
          bad++; $display("FAIL gap_beat%0d got=%h want=%h", b, beat_q[b], exp);
        end
      end
      total++;
      if (gnt_q.size() != 2 || gnt_q[0] != 3 || gnt_q[1] != 0) begin
        bad++; $display("FAIL gap_grants got=%p want='{3,0}", gnt_q);
      end
    end
  endtask

  task automatic test_async_reset();
    int k = 0;
    new_test();
    len[2] = 4; quota[2] = 5; en[2] = 1; drive();
    while (bcnt[2] < 2 && k < 10) begin
      step();
      k++;
    end
    total++;
    if (m_axis_tvalid !== 1'b1 || grant_active !== 1'b1) begin
      bad++; $display("FAIL arst_pre got=mv%b ga%b want=mv1 ga1", m_axis_tvalid, grant_active);
    end
    #2 async_reset = 1'b1;
    #1;
    total++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 4'b0 || grant_active !== 1'b0) begin
      bad++; $display("FAIL arst_immediate got=mv%b rdy%b ga%b want=mv0 rdy0000 ga0",
                      m_axis_tvalid, s_axis_tready, grant_active);
    end
    total++;
    if (m_axis_tdata !== '0 || m_axis_tlast !== 1'b0 || grant_idx !== 2'd0) begin
      bad++; $display("FAIL arst_regs got=d%h l%b gi%0d want=d0 l0 gi0", m_axis_tdata, m_axis_tlast, grant_idx);
    end
    for (int i = 0; i < 4; i++) begin bcnt[i] = 0; pkt[i] = 0; end
    len[1] = 2; quota[1] = 5; en[1] = 1;
    len[2] = 2; en[2] = 1;
    drive();
    @(posedge clk);
    @(negedge clk);
    async_reset = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (grant_active !== 1'b1 || grant_idx !== 2'd1) begin
      bad++; $display("FAIL arst_first_grant got=ga%b gi%0d want=ga1 gi1", grant_active, grant_idx);
    end
    apply_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_almost_full();
    test_backpressure();
    test_gap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_pkt_rr_arb_4.md
# axi_pkt_rr_arb_4

Packet-aware, four-input round-robin arbiter that shares the write port of a channelizer AXI-stream FIFO between four upstream requesters. A grant is held for a whole packet (until the beat carrying tlast); new grants are withheld while the downstream FIFO reports almost_full. The arbiter sits directly in front of the FIFO's s_axis port and drives it through a single registered output stage.

## Interface
- DATA_WIDTH, 32, payload width per requester and on the output
- clk  input  1  single clock; all logic on rising edge
- async_reset  input  1  asynchronous, active-high reset
- s_axis_tvalid  input  4  per-requester valid, bit i = requester i
- s_axis_tdata  input  4*DATA_WIDTH  requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tlast  input  4  per-requester end-of-packet
- s_axis_tready  output  4  per-requester ready; at most one bit high
- fifo_almost_full  input  1  from downstream FIFO; gates new grants only
- m_axis_tvalid  output  1  registered output valid
- m_axis_tdata  output  DATA_WIDTH  registered output data
- m_axis_tlast  output  1  registered output last
- m_axis_tready  input  1  downstream ready (FIFO ~full)
- grant_active  output  1  high while a packet grant is held (state ACTIVE)
- grant_idx  output  2  index of the current/most recent grant

## Operation
- States: IDLE, ACTIVE. Registers: state, grant_idx, last_grant[1:0], out stage (valid, data, last).
- Reset values: state IDLE, grant_idx 0, last_grant 3 (so requester 0 has top priority first), m_axis_tvalid 0, m_axis_tdata 0, m_axis_tlast 0, grant_active 0, s_axis_tready 0.
- out_ready = ~m_axis_tvalid | m_axis_tready (combinational).
- IDLE: all s_axis_tready low. If fifo_almost_full == 0 and any s_axis_tvalid bit set, select the first set bit searching last_grant+1, +2, +3, +4 (mod 4); register grant_idx, go ACTIVE. Otherwise stay IDLE.
- ACTIVE: s_axis_tready[grant_idx] = out_ready, other bits 0. Beat accepted when s_axis_tvalid[g] & s_axis_tready[g]; accepted beat loads out stage (valid 1, data, last).
- Accepted beat with tlast = 1: last_grant <= grant_idx, state <= IDLE.
- Grant is held across gaps: s_axis_tvalid[g] low mid-packet keeps ACTIVE indefinitely; no timeout.
- fifo_almost_full asserted while ACTIVE does not stall the packet; only m_axis_tready backpressures it.
- Out stage: if m_axis_tready & m_axis_tvalid and no new beat accepted, m_axis_tvalid <= 0. Data/last hold while m_axis_tvalid & ~m_axis_tready.
- Requester priority rotates per packet, not per beat; a requester with continuous traffic receives at most one packet per four grants when all four request.

## Timing
- Arbitration: 1 cycle in IDLE between packets; tlast accepted at edge N -> IDLE during N..N+1 -> next grant registered at edge N+1 -> first beat of next packet accepted no earlier than edge N+2.
- Data latency: beat accepted at edge N is on m_axis from after edge N to the handshake; 1 cycle.
- Full throughput inside a packet: 1 beat/cycle while m_axis_tready = 1.
- Single-beat packet (tlast on first beat): ACTIVE for exactly one cycle if out_ready.
- Simultaneous tlast acceptance and new requests: new requests are evaluated only in the following IDLE cycle.
- fifo_almost_full sampled only in IDLE; requests remain pending (no grant) while it is high.
- async_reset mid-packet: outputs go to reset values immediately; the in-flight out-stage beat is dropped; partially transferred packet is not resumed.

## Test plan
- Single requester: port 2 sends 3-beat packet A0..A2, m_axis_tready = 1 -> grant_idx 2, m_axis shows A0,A1,A2 on consecutive cycles, tlast on A2, back to IDLE.
- All four valid, each 2-beat packets, continuous -> grant order 0,1,2,3,0; one IDLE cycle between packets; no interleaving of beats.
- almost_full: port 1 valid, fifo_almost_full = 1 for 10 cycles -> no tready, grant_active 0; deassert -> grant 1 next cycle. Assert mid-packet -> packet completes uninterrupted.
- Backpressure: m_axis_tready toggles 1,0,0,1 during a 4-beat packet -> no beat lost or duplicated; tdata stable while stalled; granted tready follows out_ready.
- Gap in packet: port 3 drops tvalid for 5 cycles mid-packet while port 0 requests -> port 3 retains grant; port 0 granted only after port 3 tlast.
- Reset: assert async_reset between clock edges mid-packet -> m_axis_tvalid, s_axis_tready, grant_active low without a clock edge; after release, first grant goes to lowest-index valid requester.
